// File: rtl/radar_pkg.sv
// Shared types and helpers for the radar chirp/NCO datapath.
// Quadrant decode is reused by LUT-facing blocks.
package radar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    GAP
  } state_e;

  localparam int PHASE_W_D = 22;
  localparam int FREQ_W_D  = 22;
  localparam int WA_D      = 4;
  localparam int LEN_W_D   = 16;
  localparam int NCH_W_D   = 8;
  localparam int WA_MAX    = 16;

  // Returns {sin_sign, cos_sign, lut_addr}; odd quadrants mirror the address.
  function automatic logic [WA_MAX+1:0] quad_decode(
    input logic [1:0]        q,
    input logic [WA_MAX-1:0] raw
  );
    return {q[1], q[1] ^ q[0], q[0] ? ~raw : raw};
  endfunction

endpackage

// File: rtl/chirp_phase_acc.sv
// Frequency/phase accumulator pair for one linear-FM chirp.
// Exposes next-phase so the owner can register a matching decode.
module chirp_phase_acc #(
  parameter int PHASE_W = 22,
  parameter int FREQ_W  = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic               en,
  input  logic [FREQ_W-1:0]  f0,
  input  logic [FREQ_W-1:0]  slope,
  output logic [PHASE_W-1:0] phase,
  output logic [PHASE_W-1:0] phase_next
);

  logic [FREQ_W-1:0] freq;
  logic [FREQ_W-1:0] freq_next;

  always_comb begin
    freq_next  = freq;
    phase_next = phase;
    if (init) begin
      freq_next  = f0;
      phase_next = '0;
    end else if (en) begin
      freq_next  = freq + slope;
      phase_next = phase + PHASE_W'(freq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freq  <= '0;
      phase <= '0;
    end else begin
      freq  <= freq_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/fmcw_chirp_nco.sv
// FMCW frame sequencer: N chirps with gaps, NCO phase and
// registered quarter-wave decode plus timing strobes.
module fmcw_chirp_nco
  import radar_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_D,
  parameter int FREQ_W  = FREQ_W_D,
  parameter int WA      = WA_D,
  parameter int LEN_W   = LEN_W_D,
  parameter int NCH_W   = NCH_W_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  cfg_f0,
  input  logic [FREQ_W-1:0]  cfg_slope,
  input  logic [LEN_W-1:0]   cfg_chirp_len,
  input  logic [LEN_W-1:0]   cfg_gap_len,
  input  logic [NCH_W-1:0]   cfg_num_chirps,
  output logic               out_valid,
  output logic [PHASE_W-1:0] phase,
  output logic [WA-1:0]      lut_addr,
  output logic               sin_sign,
  output logic               cos_sign,
  output logic               chirp_start,
  output logic [NCH_W-1:0]   chirp_idx,
  output logic               busy,
  output logic               frame_done
);

  state_e             state, state_n;
  logic [LEN_W-1:0]   cnt, cnt_n;
  logic [NCH_W-1:0]   idx, idx_n;
  logic [FREQ_W-1:0]  f0_r, slope_r, f0_n;
  logic [LEN_W-1:0]   len_r, gap_r, len_n;
  logic [NCH_W-1:0]   num_r, num_n;
  logic               go, acc_init, acc_en;
  logic               run_n, done_n;
  logic [PHASE_W-1:0] phase_n;
  logic [WA_MAX+1:0]  dec;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    go       = 1'b0;
    acc_init = 1'b0;
    acc_en   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!abort && start &&
            cfg_chirp_len != '0 &&
            cfg_num_chirps != '0) begin
          go       = 1'b1;
          state_n  = RAMP;
          acc_init = 1'b1;
        end
      end
      RAMP: begin
        if (abort) begin
          state_n  = IDLE;
          cnt_n    = '0;
          idx_n    = '0;
          acc_init = 1'b1;
        end else if (cnt == len_r - LEN_W'(1)) begin
          cnt_n = '0;
          if (idx == num_r - NCH_W'(1)) begin
            state_n = IDLE;
            idx_n   = '0;
          end else if (gap_r != '0) begin
            state_n = GAP;
          end else begin
            idx_n    = idx + NCH_W'(1);
            acc_init = 1'b1;
          end
        end else begin
          cnt_n  = cnt + LEN_W'(1);
          acc_en = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_n  = IDLE;
          cnt_n    = '0;
          idx_n    = '0;
          acc_init = 1'b1;
        end else if (cnt == gap_r - LEN_W'(1)) begin
          state_n  = RAMP;
          cnt_n    = '0;
          idx_n    = idx + NCH_W'(1);
          acc_init = 1'b1;
        end else begin
          cnt_n = cnt + LEN_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // Config in effect on the next cycle, so strobes line up with the start edge.
  assign f0_n  = go ? cfg_f0 : f0_r;
  assign len_n = go ? cfg_chirp_len : len_r;
  assign num_n = go ? cfg_num_chirps : num_r;

  assign run_n  = (state_n == RAMP);
  assign done_n = run_n &&
                  cnt_n == len_n - LEN_W'(1) &&
                  idx_n == num_n - NCH_W'(1);

  chirp_phase_acc #(
    .PHASE_W (PHASE_W),
    .FREQ_W  (FREQ_W)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .init       (acc_init),
    .en         (acc_en),
    .f0         (f0_n),
    .slope      (slope_r),
    .phase      (phase),
    .phase_next (phase_n)
  );

  assign dec = quad_decode(phase_n[PHASE_W-1 -: 2],
                           WA_MAX'(phase_n[PHASE_W-3 -: WA]));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      f0_r        <= '0;
      slope_r     <= '0;
      len_r       <= '0;
      gap_r       <= '0;
      num_r       <= '0;
      out_valid   <= 1'b0;
      chirp_start <= 1'b0;
      chirp_idx   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      lut_addr    <= '0;
      sin_sign    <= 1'b0;
      cos_sign    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      if (go) begin
        f0_r    <= cfg_f0;
        slope_r <= cfg_slope;
        len_r   <= cfg_chirp_len;
        gap_r   <= cfg_gap_len;
        num_r   <= cfg_num_chirps;
      end
      out_valid   <= run_n;
      chirp_start <= run_n && cnt_n == '0;
      chirp_idx   <= idx_n;
      busy        <= state_n != IDLE;
      frame_done  <= done_n;
      lut_addr    <= dec[WA-1:0];
      sin_sign    <= dec[WA_MAX+1];
      cos_sign    <= dec[WA_MAX];
    end
  end

endmodule

// File: tb/tb_fmcw_chirp_nco.sv
// Directed-vector bench for fmcw_chirp_nco with hand-computed
// phase, decode and strobe expectations.
module tb_fmcw_chirp_nco;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [21:0] cfg_f0;
  logic [21:0] cfg_slope;
  logic [15:0] cfg_chirp_len;
  logic [15:0] cfg_gap_len;
  logic [7:0]  cfg_num_chirps;
  logic        out_valid;
  logic [21:0] phase;
  logic [3:0]  lut_addr;
  logic        sin_sign;
  logic        cos_sign;
  logic        chirp_start;
  logic [7:0]  chirp_idx;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fmcw_chirp_nco dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_f0         (cfg_f0),
    .cfg_slope      (cfg_slope),
    .cfg_chirp_len  (cfg_chirp_len),
    .cfg_gap_len    (cfg_gap_len),
    .cfg_num_chirps (cfg_num_chirps),
    .out_valid      (out_valid),
    .phase          (phase),
    .lut_addr       (lut_addr),
    .sin_sign       (sin_sign),
    .cos_sign       (cos_sign),
    .chirp_start    (chirp_start),
    .chirp_idx      (chirp_idx),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  typedef struct packed {
    logic [21:0]        f0;
    logic [21:0]        slope;
    logic [15:0]        len;
    logic [15:0]        gap;
    logic [7:0]         num;
    logic [15:0]        cycles;
    logic [0:4][21:0]   ph;
    logic [0:4][1:0]    sc;
    logic [0:4][3:0]    addr;
    logic               poke;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " phase"}, 32'(phase), 0);
    chk({tag, " lut_addr"}, 32'(lut_addr), 0);
    chk({tag, " sin"}, 32'(sin_sign), 0);
    chk({tag, " cos"}, 32'(cos_sign), 0);
    chk({tag, " chirp_start"}, 32'(chirp_start), 0);
    chk({tag, " chirp_idx"}, 32'(chirp_idx), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " frame_done"}, 32'(frame_done), 0);
  endtask

  task automatic set_cfg(input logic [21:0] f0, input logic [21:0] sl,
                         input logic [15:0] ln, input logic [15:0] gp,
                         input logic [7:0] nm);
    cfg_f0         = f0;
    cfg_slope      = sl;
    cfg_chirp_len  = ln;
    cfg_gap_len    = gp;
    cfg_num_chirps = nm;
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    int    period, pos, ci;
    bit    ev;
    string t;
    v = vt[i];
    @(negedge clk);
    set_cfg(v.f0, v.slope, v.len, v.gap, v.num);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    period = int'(v.len) + int'(v.gap);
    for (int c = 0; c < int'(v.cycles) + 2; c++) begin
      pos = c % period;
      ci  = c / period;
      ev  = (c < int'(v.cycles)) && (pos < int'(v.len));
      t   = $sformatf("v%0d c%0d", i, c);
      chk({t, " valid"}, 32'(out_valid), 32'(ev));
      chk({t, " busy"}, 32'(busy), 32'(c < int'(v.cycles)));
      chk({t, " done"}, 32'(frame_done), 32'(c == int'(v.cycles) - 1));
      if (ev) begin
        chk({t, " phase"}, 32'(phase), 32'(v.ph[pos]));
        chk({t, " sincos"}, 32'({sin_sign, cos_sign}), 32'(v.sc[pos]));
        chk({t, " addr"}, 32'(lut_addr), 32'(v.addr[pos]));
        chk({t, " cstart"}, 32'(chirp_start), 32'(pos == 0));
        chk({t, " idx"}, 32'(chirp_idx), 32'(ci));
      end else if (c >= int'(v.cycles)) begin
        chk({t, " held"}, 32'(phase), 32'(v.ph[int'(v.len) - 1]));
        chk({t, " idx0"}, 32'(chirp_idx), 0);
      end
      if (v.poke && c == 4) begin
        start = 1'b1;
        set_cfg(22'd999, 22'd5, 16'd1, 16'd0, 8'd1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic ignored_start(input string tag, input bit ab,
                               input logic [21:0] hold_ph);
    @(negedge clk);
    start = 1'b1;
    abort = ab;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 0);
      chk($sformatf("%s valid c%0d", tag, c), 32'(out_valid), 0);
      chk($sformatf("%s phase c%0d", tag, c), 32'(phase), 32'(hold_ph));
      @(negedge clk);
    end
  endtask

  initial begin
    vt[0] = '{f0: 22'd100, slope: 22'd0, len: 16'd4, gap: 16'd0,
              num: 8'd1, cycles: 16'd4,
              ph: {22'd0, 22'd100, 22'd200, 22'd300, 22'd0},
              sc: '0, addr: '0, poke: 1'b0};
    vt[1] = '{f0: 22'd100, slope: 22'd10, len: 16'd4, gap: 16'd0,
              num: 8'd1, cycles: 16'd4,
              ph: {22'd0, 22'd100, 22'd210, 22'd330, 22'd0},
              sc: '0, addr: '0, poke: 1'b0};
    vt[2] = '{f0: 22'd50, slope: 22'd0, len: 16'd3, gap: 16'd2,
              num: 8'd3, cycles: 16'd13,
              ph: {22'd0, 22'd50, 22'd100, 22'd0, 22'd0},
              sc: '0, addr: '0, poke: 1'b1};
    vt[3] = '{f0: 22'h100000, slope: 22'd0, len: 16'd5, gap: 16'd0,
              num: 8'd1, cycles: 16'd5,
              ph: {22'h000000, 22'h100000, 22'h200000,
                   22'h300000, 22'h000000},
              sc: {2'b00, 2'b01, 2'b11, 2'b10, 2'b00},
              addr: {4'h0, 4'hF, 4'h0, 4'hF, 4'h0}, poke: 1'b0};
    vt[4] = '{f0: 22'd7, slope: 22'd3, len: 16'd2, gap: 16'd0,
              num: 8'd2, cycles: 16'd4,
              ph: {22'd0, 22'd7, 22'd0, 22'd0, 22'd0},
              sc: '0, addr: '0, poke: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    set_cfg('0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Abort in the second cycle of chirp 1 (frame cycle 6).
    @(negedge clk);
    set_cfg(22'd50, 22'd0, 16'd3, 16'd2, 8'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 6; c++) @(negedge clk);
    chk("abort pre phase", 32'(phase), 32'd50);
    chk("abort pre idx", 32'(chirp_idx), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_zero("abort");
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("abort nodone c%0d", c), 32'(frame_done), 0);
      chk($sformatf("abort nobusy c%0d", c), 32'(busy), 0);
      @(negedge clk);
    end
    run_vec(0);

    // Synchronous reset while in the inter-chirp gap.
    @(negedge clk);
    set_cfg(22'd50, 22'd0, 16'd3, 16'd2, 8'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3; c++) @(negedge clk);
    chk("gap valid", 32'(out_valid), 0);
    chk("gap held", 32'(phase), 32'd100);
    chk("gap busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("rst gap");
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("rst nodone c%0d", c), 32'(frame_done), 0);
      chk($sformatf("rst nobusy c%0d", c), 32'(busy), 0);
      @(negedge clk);
    end
    run_vec(1);

    set_cfg(22'd100, 22'd0, 16'd0, 16'd0, 8'd1);
    ignored_start("len0", 1'b0, 22'd330);
    set_cfg(22'd100, 22'd0, 16'd4, 16'd0, 8'd0);
    ignored_start("num0", 1'b0, 22'd330);
    set_cfg(22'd100, 22'd0, 16'd4, 16'd0, 8'd1);
    ignored_start("start+abort", 1'b1, 22'd330);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
